// File: rtl/hart_pc_sequencer.sv
// hart_pc_sequencer: per-hart PC store with round-robin issue to fetch.
// Each cycle the next hart in rotation is presented to fetch with its
// stored PC. A hart stays pending from its issue until its next PC is
// written back, and a pending hart produces a bubble in its slot.
//
// Handshake semantics: there is no back-pressure anywhere in this block.
// i_next_pc_valid is a single-cycle write strobe that is always accepted,
// also while stalled. o_issue_valid qualifies the current issue slot; the
// downstream stage consumes it on any clock edge where i_stall is low.
// While i_stall is high, the slot is held unchanged.
module hart_pc_sequencer #(
    parameter int NUM_HARTS = 16,
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    localparam int HART_ID_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_stall,
    input  logic                     i_next_pc_valid,
    input  logic [HART_ID_WIDTH-1:0] i_next_pc_hart_id,
    input  logic [PC_WIDTH-1:0]      i_next_pc,
    output logic                     o_issue_valid,
    output logic [HART_ID_WIDTH-1:0] o_issue_hart_id,
    output logic [PC_WIDTH-1:0]      o_issue_pc,
    output logic [NUM_HARTS-1:0]     o_pending_mask
);

    localparam int LAST_INT = NUM_HARTS - 1;
    localparam logic [HART_ID_WIDTH-1:0] LAST_ID = LAST_INT[HART_ID_WIDTH-1:0];

    logic [HART_ID_WIDTH-1:0] cnt;
    logic [PC_WIDTH-1:0]      slot [NUM_HARTS];
    logic [NUM_HARTS-1:0]     pending;
    logic [NUM_HARTS-1:0]     pending_next;

    logic                wr_ok;
    logic                bypass;
    logic [PC_WIDTH-1:0] wr_pc;
    logic [PC_WIDTH-1:0] eff_pc;
    logic                eff_pend;
    logic                issue_fire;

    // Instruction fetch PCs are word aligned, so the low two bits are dropped.
    assign wr_pc = i_next_pc & ~(PC_WIDTH'(3));

    assign o_pending_mask = pending;

    // Accept writes for real harts only; when the write targets the hart being
    // selected this cycle, forward it so the returning PC is not missed.
    always_comb begin
        wr_ok      = i_next_pc_valid && (i_next_pc_hart_id <= LAST_ID);
        bypass     = wr_ok && (i_next_pc_hart_id == cnt);
        eff_pc     = bypass ? wr_pc : slot[cnt];
        eff_pend   = bypass ? 1'b0 : pending[cnt];
        issue_fire = !i_stall && !eff_pend;
    end

    // Pending update: write-back clears, issue sets; the set is applied last
    // so it wins when both hit the same hart in one cycle.
    always_comb begin
        pending_next = pending;
        if (wr_ok) begin
            pending_next[i_next_pc_hart_id] = 1'b0;
        end
        if (issue_fire) begin
            pending_next[cnt] = 1'b1;
        end
    end

    // Rotation counter and registered issue slot; both freeze while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= '0;
            o_issue_valid   <= 1'b0;
            o_issue_hart_id <= '0;
            o_issue_pc      <= '0;
        end else if (!i_stall) begin
            o_issue_hart_id <= cnt;
            o_issue_pc      <= eff_pc;
            o_issue_valid   <= !eff_pend;
            cnt             <= (cnt == LAST_ID) ? '0 : cnt + 1'b1;
        end
    end

    // PC slot storage and pending bits; writes land regardless of stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                slot[h] <= RESET_PC;
            end
            pending <= '0;
        end else begin
            pending <= pending_next;
            if (wr_ok) begin
                slot[i_next_pc_hart_id] <= wr_pc;
            end
        end
    end

endmodule

// File: tb/tb_hart_pc_sequencer.sv
// Bench for hart_pc_sequencer: one 16-hart and one 12-hart instance run side
// by side against a behavioural model; directed scenarios then random traffic.
module tb_hart_pc_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- per-instance stimulus (0: 16 harts, 1: 12 harts) ----------------
    logic [1:0]  stall;
    logic [1:0]  wv;
    logic [3:0]  wid [2];
    logic [31:0] wpc [2];

    logic        o_v16, o_v12;
    logic [3:0]  o_id16, o_id12;
    logic [31:0] o_pc16, o_pc12;
    logic [15:0] o_mask16;
    logic [11:0] o_mask12;

    hart_pc_sequencer #(.NUM_HARTS(16), .PC_WIDTH(32), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .reset_n(reset_n), .i_stall(stall[0]),
        .i_next_pc_valid(wv[0]), .i_next_pc_hart_id(wid[0]), .i_next_pc(wpc[0]),
        .o_issue_valid(o_v16), .o_issue_hart_id(o_id16), .o_issue_pc(o_pc16),
        .o_pending_mask(o_mask16)
    );

    hart_pc_sequencer #(.NUM_HARTS(12), .PC_WIDTH(32), .RESET_PC(32'h0)) dut12 (
        .clk(clk), .reset_n(reset_n), .i_stall(stall[1]),
        .i_next_pc_valid(wv[1]), .i_next_pc_hart_id(wid[1]), .i_next_pc(wpc[1]),
        .o_issue_valid(o_v12), .o_issue_hart_id(o_id12), .o_issue_pc(o_pc12),
        .o_pending_mask(o_mask12)
    );

    // ---------------- reference model ----------------
    int          m_n [2] = '{16, 12};
    logic [31:0] m_slot [2][64];
    bit          m_pend [2][64];
    int          m_cnt [2];
    bit          m_ov [2];
    int          m_oid [2];
    logic [31:0] m_opc [2];

    int checks = 0;
    int failures = 0;

    function automatic void model_reset(input int k);
        for (int h = 0; h < 64; h++) begin
            m_slot[k][h] = 32'h0;
            m_pend[k][h] = 1'b0;
        end
        m_cnt[k] = 0;
        m_ov[k]  = 1'b0;
        m_oid[k] = 0;
        m_opc[k] = 32'h0;
    endfunction

    // One clock edge of behaviour, using the inputs present before the edge.
    function automatic void model_step(input int k);
        int n, c, id;
        bit ok, hit;
        logic [31:0] al;
        n  = m_n[k];
        c  = m_cnt[k];
        id = int'(wid[k]);
        ok = wv[k] && (id < n);
        al = (wpc[k] / 4) * 4;
        if (!stall[k]) begin
            hit      = ok && (id == c);
            m_oid[k] = c;
            m_opc[k] = hit ? al : m_slot[k][c];
            m_ov[k]  = hit ? 1'b1 : !m_pend[k][c];
        end
        if (ok) begin
            m_slot[k][id] = al;
            m_pend[k][id] = 1'b0;
        end
        if (!stall[k]) begin
            if (m_ov[k]) m_pend[k][c] = 1'b1;
            m_cnt[k] = (c + 1) % n;
        end
    endfunction

    function automatic logic [63:0] model_mask(input int k);
        logic [63:0] m;
        m = '0;
        for (int h = 0; h < m_n[k]; h++) m[h] = m_pend[k][h];
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int k);
        logic [63:0] v, id, pc, mk;
        if (k == 0) begin
            v = 64'(o_v16); id = 64'(o_id16); pc = 64'(o_pc16); mk = 64'(o_mask16);
        end else begin
            v = 64'(o_v12); id = 64'(o_id12); pc = 64'(o_pc12); mk = 64'(o_mask12);
        end
        check($sformatf("i%0d_valid", k), v, 64'(m_ov[k]));
        check($sformatf("i%0d_hart", k), id, 64'(m_oid[k]));
        check($sformatf("i%0d_pc", k), pc, 64'(m_opc[k]));
        check($sformatf("i%0d_mask", k), mk, model_mask(k));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic idle_inputs();
        stall = 2'b00;
        wv    = 2'b00;
        wid[0] = '0; wid[1] = '0;
        wpc[0] = '0; wpc[1] = '0;
    endtask

    // return delay line for write-back scenario
    bit          dl_v [3];
    logic [3:0]  dl_id [3];
    logic [31:0] dl_pc [3];

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset(0);
        model_reset(1);
        #12;
        check_all(0);
        check_all(1);
        reset_n = 1'b1;

        // Round one with no write-backs; the 12-hart instance sees an
        // out-of-range write that must be ignored.
        for (int i = 0; i < 17; i++) begin
            if (i == 3) begin
                wv[1] = 1'b1; wid[1] = 4'd13; wpc[1] = 32'h0000_0ABC;
            end
            tick();
            wv[1] = 1'b0;
            if (i < 16) begin
                check("r1_hart", 64'(o_id16), 64'(i));
                check("r1_pc", 64'(o_pc16), 64'h0);
                check("r1_valid", 64'(o_v16), 64'h1);
            end else begin
                check("r1_wrap_hart", 64'(o_id16), 64'h0);
                check("r1_wrap_valid", 64'(o_v16), 64'h0);
                check("r1_mask", 64'(o_mask16), 64'hFFFF);
            end
            if (i == 11) check("n12_last", 64'(o_id12), 64'd11);
            if (i == 12) begin
                check("n12_wrap_hart", 64'(o_id12), 64'h0);
                check("n12_wrap_valid", 64'(o_v12), 64'h0);
                check("n12_mask", 64'(o_mask12), 64'hFFF);
            end
        end

        // Same-cycle bypass: write hart 5 while it is being selected.
        for (int i = 0; i < 4; i++) tick();
        wv[0] = 1'b1; wid[0] = 4'd5; wpc[0] = 32'h0000_0103;
        tick();
        wv[0] = 1'b0;
        check("byp_hart", 64'(o_id16), 64'd5);
        check("byp_pc", 64'(o_pc16), 64'h100);
        check("byp_valid", 64'(o_v16), 64'h1);
        check("byp_pend5", 64'(o_mask16[5]), 64'h1);

        // Stall for three cycles with hart 7 on the outputs; write hart 2 meanwhile.
        tick();
        tick();
        check("stall_pre", 64'(o_id16), 64'd7);
        stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                wv[0] = 1'b1; wid[0] = 4'd2; wpc[0] = 32'h0000_0200;
            end
            tick();
            wv[0] = 1'b0;
            check("stall_hold", 64'(o_id16), 64'd7);
        end
        stall[0] = 1'b0;
        tick();
        check("stall_next", 64'(o_id16), 64'd8);
        for (int i = 0; i < 10; i++) tick();
        check("h2_hart", 64'(o_id16), 64'd2);
        check("h2_pc", 64'(o_pc16), 64'h200);
        check("h2_valid", 64'(o_v16), 64'h1);

        // Asynchronous reset while hart 9 is on the outputs.
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_hart", 64'(o_id16), 64'd9);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all(0);
        check_all(1);
        check("rst_pc", 64'(o_pc16), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_hart", 64'(o_id16), 64'h0);
        check("post_rst_pc", 64'(o_pc16), 64'h0);
        check("post_rst_valid", 64'(o_v16), 64'h1);

        // Write back pc+4 three cycles after each issue: round two has no bubbles.
        for (int j = 0; j < 3; j++) begin
            dl_v[j] = 1'b0; dl_id[j] = '0; dl_pc[j] = '0;
        end
        dl_v[0] = m_ov[0]; dl_id[0] = 4'(m_oid[0]); dl_pc[0] = m_opc[0];
        for (int t = 2; t <= 32; t++) begin
            wv[0]  = dl_v[2];
            wid[0] = dl_id[2];
            wpc[0] = dl_pc[2] + 32'd4;
            tick();
            for (int j = 2; j > 0; j--) begin
                dl_v[j] = dl_v[j-1]; dl_id[j] = dl_id[j-1]; dl_pc[j] = dl_pc[j-1];
            end
            dl_v[0] = m_ov[0]; dl_id[0] = 4'(m_oid[0]); dl_pc[0] = m_opc[0];
            if (t >= 17) begin
                check("r2_hart", 64'(o_id16), 64'(t - 17));
                check("r2_pc", 64'(o_pc16), 64'h4);
                check("r2_valid", 64'(o_v16), 64'h1);
            end
        end
        idle_inputs();

        // Random traffic: stalls, in-range and out-of-range writes, bypass hits.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                stall[k] = ($urandom_range(0, 3) == 0);
                wv[k]    = 1'($urandom_range(0, 1));
                wid[k]   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) wid[k] = 4'(m_cnt[k]);
                wpc[k]   = $urandom;
            end
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
